interrupt_controller: RTL
=========================

// Module: interrupt_controller
// PURPOSE
//  Parametrised nested-interrupt controller for the rk2040 core; successor to the fixed 8-source handler.
//  Latches level/edge requests per channel, masks and prioritises them (higher index = higher priority).
//  Hands one vector at a time to the pipeline via a valid/ack handshake, tracks nesting, retires on RETI.
//  Sits between peripheral IRQ lines and the fetch/decode stage; the core performs the actual push/jump.
// PARAMETERS
//  NUM_IRQ     8      number of interrupt channels, 1..16
//  PC_W        10     program-address width of irq_vector
//  VEC_BASE    988    ISR address of channel NUM_IRQ-1
//  VEC_STRIDE  3      address spacing between consecutive ISR slots
//  EDGE_MODE   0      NUM_IRQ-bit mask; bit=1 -> channel is rising-edge, 0 -> level
// PORTS
//  clk         in   1        system clock
//  rst         in   1        synchronous, active-high reset
//  irq_in      in   NUM_IRQ  raw request lines (already synchronous to clk)
//  irq_mask    in   NUM_IRQ  1 = channel enabled
//  gie         in   1        global interrupt enable
//  irq_clr     in   NUM_IRQ  software clear of pending bits (one-cycle pulse per bit)
//  entry_ok    in   1        core at a safe boundary (no branch/pop in flight)
//  irq_ack     in   1        core accepted the presented vector
//  reti        in   1        core executed return-from-interrupt (one-cycle pulse)
//  irq_valid   out  1        vector presented, hold until irq_ack
//  irq_vector  out  PC_W     ISR address = VEC_BASE + VEC_STRIDE*(NUM_IRQ-1-irq_id)
//  irq_id      out  $clog2(NUM_IRQ)  channel being entered
//  stall_pc    out  1        freeze PC while a vector is presented
//  irq_active  out  NUM_IRQ  channels currently in service (nesting set)
//  irq_pending out  NUM_IRQ  latched, not-yet-entered requests
// BEHAVIOUR
//  Reset: all outputs 0, pending=0, active=0, edge history=0, state=IDLE.
//  Pending: level chan: pending[i] <= irq_in[i]; edge chan: set on irq_in[i]&~prev[i], held until entered or irq_clr.
//   irq_clr wins over a same-cycle set. Mask does NOT clear pending; it only gates eligibility.
//  Eligible = pending & irq_mask & ~active, gated by gie. cand = highest eligible index.
//  Preempt rule: cand taken only if cand > highest set bit of active (active=0 -> any cand).
//  FSM states IDLE, REQ, HOLDOFF, RET:
//   IDLE: reti -> RET (reti has priority over entry in the same cycle).
//         else eligible & preempt rule & entry_ok -> REQ; latch irq_id/irq_vector at this edge.
//   REQ:  irq_valid=1, stall_pc=1, id/vector stable (no re-arbitration even if higher irq arrives).
//         irq_ack -> active[id]<=1, pending[id]<=0 (edge chan), -> HOLDOFF. No timeout.
//         gie falling while in REQ does not withdraw the request.
//   HOLDOFF: one cycle, no new entry, outputs 0 -> IDLE (lets ISR first instruction issue).
//   RET: clear highest set bit of active (no-op if active=0) -> IDLE. reti outside IDLE ignored
//        in REQ/HOLDOFF is latched as ret_pend and serviced on next IDLE.
//  Latency: eligible request with entry_ok high -> irq_valid on the next cycle.
//  Vector arithmetic done at PC_W bits, wrap-around modulo 2^PC_W is the defined result.
//  rst mid-handshake: return to IDLE, drop active/pending; an irq_ack in that cycle is ignored.
// STRUCTURE
//  Shared package/header: FSM state encodings, irq_vec_addr(id) function, NUM_IRQ max constant.
//  Sub-module irq_priority_enc: NUM_IRQ-bit vector -> {found, index of highest set bit};
//   instantiated twice (eligible candidate, highest active). All else in one file.
// TESTING
//  1 rst, irq_mask=FF, gie=1, entry_ok=1, pulse irq_in[3] (level held) -> irq_valid next cycle, irq_id=3, irq_vector=1000.
//  2 in ISR 3 (active=08): raise irq_in[7] -> vector 988, active=88; raise irq_in[1] -> no entry until two retis.
//  3 irq_in[2] and irq_in[5] together, entry_ok=0 for 4 cycles -> no irq_valid; entry_ok=1 -> id=5 first.
//  4 EDGE_MODE=01: one-cycle pulse on irq_in[0] while masked -> pending[0]=1; unmask -> vector 1009; irq_clr before unmask -> none.
//  5 reti and new eligible request same cycle in IDLE -> RET taken first, active MSB cleared, entry next IDLE.
//  6 rst asserted while irq_valid=1 and irq_ack=1 -> next cycle all outputs 0, active=00.

Source files
------------

// File: rtl/interrupt_controller_pkg.sv
// Shared definitions for the nested interrupt controller: FSM states,
// channel limit and the ISR address helper.
package interrupt_controller_pkg;

    localparam int MAX_IRQ = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        HOLDOFF = 2'd2,
        RET     = 2'd3
    } irq_state_t;

    // The caller truncates to the PC width, so the address wraps modulo 2^PC_W.
    function automatic logic [31:0] irq_vec_addr(input int unsigned id,
                                                 input int unsigned num_irq,
                                                 input int unsigned base,
                                                 input int unsigned stride);
        return base + stride * (num_irq - 1 - id);
    endfunction

endpackage

// File: rtl/irq_priority_enc.sv
// Finds the highest set bit of a request vector and reports whether any bit is set.
module irq_priority_enc #(
    parameter int W     = 8,
    parameter int IDX_W = 3
) (
    input  logic [W-1:0]     vec,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < W; i++) begin
            if (vec[i]) begin
                found = 1'b1;
                idx   = i[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// Nested interrupt controller: latches level/edge requests, arbitrates by index,
// presents one vector at a time via valid/ack and tracks the in-service set.
module interrupt_controller
    import interrupt_controller_pkg::*;
#(
    parameter int                 NUM_IRQ    = 8,
    parameter int                 PC_W       = 10,
    parameter int                 VEC_BASE   = 988,
    parameter int                 VEC_STRIDE = 3,
    parameter logic [NUM_IRQ-1:0] EDGE_MODE  = '0,
    localparam int                ID_W       = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic [NUM_IRQ-1:0] irq_mask,
    input  logic               gie,
    input  logic [NUM_IRQ-1:0] irq_clr,
    input  logic               entry_ok,
    input  logic               irq_ack,
    input  logic               reti,
    output logic               irq_valid,
    output logic [PC_W-1:0]    irq_vector,
    output logic [ID_W-1:0]    irq_id,
    output logic               stall_pc,
    output logic [NUM_IRQ-1:0] irq_active,
    output logic [NUM_IRQ-1:0] irq_pending
);

    irq_state_t         state;
    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] pending_next;
    logic [NUM_IRQ-1:0] active;
    logic [NUM_IRQ-1:0] prev_in;
    logic [NUM_IRQ-1:0] eligible;
    logic               ret_pend;
    logic               cand_found;
    logic               act_found;
    logic [ID_W-1:0]    cand_id;
    logic [ID_W-1:0]    act_top;
    logic               preempt_ok;
    logic               ack_take;

    assign eligible   = pending & irq_mask & ~active & {NUM_IRQ{gie}};
    assign preempt_ok = cand_found && (!act_found || (cand_id > act_top));
    assign ack_take   = (state == REQ) && irq_ack;

    assign irq_active  = active;
    assign irq_pending = pending;

    irq_priority_enc #(.W(NUM_IRQ), .IDX_W(ID_W)) u_cand_enc (
        .vec   (eligible),
        .found (cand_found),
        .idx   (cand_id)
    );

    irq_priority_enc #(.W(NUM_IRQ), .IDX_W(ID_W)) u_active_enc (
        .vec   (active),
        .found (act_found),
        .idx   (act_top)
    );

    // Edge channels hold until entered; level channels mirror the line; clear wins last.
    always_comb begin
        pending_next = pending;
        if (ack_take) begin
            pending_next[irq_id] = pending[irq_id] & ~EDGE_MODE[irq_id];
        end
        pending_next = pending_next | (irq_in & ~prev_in & EDGE_MODE);
        pending_next = (pending_next & EDGE_MODE) | (irq_in & ~EDGE_MODE);
        pending_next = pending_next & ~irq_clr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
            prev_in <= '0;
        end else begin
            pending <= pending_next;
            prev_in <= irq_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            active     <= '0;
            ret_pend   <= 1'b0;
            irq_valid  <= 1'b0;
            stall_pc   <= 1'b0;
            irq_id     <= '0;
            irq_vector <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // A return queued during a handshake keeps a second one alive.
                    if (reti || ret_pend) begin
                        state    <= RET;
                        ret_pend <= reti && ret_pend;
                    end else if (preempt_ok && entry_ok) begin
                        state      <= REQ;
                        irq_valid  <= 1'b1;
                        stall_pc   <= 1'b1;
                        irq_id     <= cand_id;
                        irq_vector <= PC_W'(irq_vec_addr(32'(cand_id), NUM_IRQ,
                                                         VEC_BASE, VEC_STRIDE));
                    end
                end
                REQ: begin
                    if (reti) begin
                        ret_pend <= 1'b1;
                    end
                    if (irq_ack) begin
                        active[irq_id] <= 1'b1;
                        state          <= HOLDOFF;
                        irq_valid      <= 1'b0;
                        stall_pc       <= 1'b0;
                        irq_id         <= '0;
                        irq_vector     <= '0;
                    end
                end
                HOLDOFF: begin
                    if (reti) begin
                        ret_pend <= 1'b1;
                    end
                    state <= IDLE;
                end
                RET: begin
                    if (act_found) begin
                        active[act_top] <= 1'b0;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
